// File: rtl/seq_mult_n.sv
// Sequential shift-add multiplier: N-bit operands, 2N-bit product, signed or unsigned per operation.
// Operands are captured on start; one add step and one shift step per multiplier bit.
module seq_mult_n #(
  parameter int unsigned N = 8
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic           i_start,
  input  logic           i_signed_mode,
  input  logic [N-1:0]   i_mcand,
  input  logic [N-1:0]   i_mplier,
  output logic           o_busy,
  output logic           o_done,
  output logic [2*N-1:0] o_product
);

  localparam int unsigned CW = $clog2(N) + 1;
  localparam int unsigned NW = N + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADD   = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          r_state;
  logic            r_x;
  logic [N-1:0]    r_a;
  logic [N-1:0]    r_b;
  logic [N-1:0]    r_m;
  logic            r_mode;
  logic [CW-1:0]   r_cnt;
  logic            r_busy;
  logic            r_done;

  logic            w_last;
  logic            w_xin;
  logic [NW-1:0]   w_ext_a;
  logic [NW-1:0]   w_ext_m;
  logic [NW-1:0]   w_sum;

  // The final signed step subtracts: the multiplier's MSB carries weight -2^(N-1).
  always_comb begin
    w_last  = (r_cnt == LAST_STEP);
    w_xin   = r_mode ? r_x : 1'b0;
    w_ext_a = r_mode ? {r_a[N-1], r_a} : {1'b0, r_a};
    w_ext_m = r_mode ? {r_m[N-1], r_m} : {1'b0, r_m};
    if (r_mode && w_last) begin
      w_sum = w_ext_a + ~w_ext_m + NW'(1);
    end else begin
      w_sum = w_ext_a + w_ext_m;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_x     <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_m     <= '0;
      r_mode  <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_m     <= i_mcand;
            r_b     <= i_mplier;
            r_a     <= '0;
            r_x     <= 1'b0;
            r_mode  <= i_signed_mode;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_ADD;
          end
        end
        S_ADD: begin
          if (r_b[0]) begin
            {r_x, r_a} <= w_sum;
          end
          r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          {r_x, r_a, r_b} <= {w_xin, r_x, r_a, r_b[N-1:1]};
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_state <= S_ADD;
          end
        end
        S_DONE: begin
          // A held start keeps us here so it cannot launch a second multiply.
          if (!i_start) begin
            r_done  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_product = {r_a, r_b};

endmodule

// File: doc/seq_mult_n.md
# seq_mult_n

Parametrised sequential shift-add multiplier: N-bit operands, 2N-bit product, signed (two's-complement) or unsigned mode selected per operation. It folds the X/A/B shift-register datapath and its add/subtract control into one self-sequencing block with a start/done handshake. The block sits between the switch/operand front end and the display/result logic. Operands are captured at start, so inputs may change during a multiply.

## Interface
- N, default 8: operand width; legal N >= 2. Internal counter is $clog2(N)+1 bits.
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high; one clock, synchronous reset, sampled on rising edge of clk.
- start  in  1  request; level-sampled in IDLE.
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; captured with operands.
- mcand  in  N  multiplicand (M), captured at start.
- mplier  in  N  multiplier, captured into B at start.
- busy  out  1  high in ADD and SHIFT states.
- done  out  1  high in DONE state only.
- product  out  2N  {A,B}; final result valid while done=1 and retained in IDLE.

## Operation
- Registers: X (1), A (N), B (N), M (N), mode (1), cnt, state.
- States: IDLE, ADD, SHIFT, DONE.
- IDLE: if start=1 then M<=mcand, B<=mplier, A<=0, X<=0, mode<=signed_mode, cnt<=0, go to ADD. Otherwise hold all registers.
- ADD: if B[0]=0, hold X/A. If B[0]=1, compute an (N+1)-bit sum.
  - Signed, cnt<N-1: {X,A} <= sext(A)+sext(M).
  - Signed, cnt=N-1: {X,A} <= sext(A)-sext(M), computed as sext(A)+~sext(M)+1.
  - Unsigned, any cnt: {X,A} <= {0,A}+{0,M}; X is the carry out.
  - Go to SHIFT.
- SHIFT: {X,A,B} <= {Xin, X, A, B[N-1:1]} right by one, where Xin = X if mode=1 (arithmetic) and 0 if mode=0.
  - cnt <= cnt+1.
  - If cnt=N-1 before the increment, go to DONE; else go to ADD.
- DONE: done=1 and product={A,B}. Stay while start=1; go to IDLE when start=0. A held start never launches a second multiply.
- start is ignored in ADD/SHIFT. mcand, mplier and signed_mode are ignored except on the IDLE capture edge.
- reset in any state: next edge gives state=IDLE and X, A, B, M, mode, cnt all 0. So busy=0, done=0, product=0. Reset wins over start on the same edge.
- Width rules: all sums are N+1 bits and discard the carry beyond X. Results are exact for all operand pairs, including signed (-2^(N-1))×(-2^(N-1)) = 2^(2N-2) and unsigned (2^N-1)^2.

## Timing
- Reset values: busy=0, done=0, product=0.
- Fixed latency, independent of operand bits: with the start-sampling edge counted as edge 1, ADD/SHIFT occupy edges 2..2N+1 and done rises after edge 2N+1. For N=8, done is first high 17 edges after start is sampled.
- busy is high from after edge 1 until after edge 2N+1. busy and done are never high together.
- Back-to-back throughput: DONE -> IDLE needs start=0 for one cycle, then start=1 is sampled on the following edge. Minimum period is 2N+3 cycles.
- product changes during busy (intermediate {A,B}). It is stable from done rising until the next accepted start.

## Test plan
- Reset mid-operation: start, then assert reset for 1 cycle on the 5th busy cycle -> next cycle state=IDLE, busy=0, done=0, product=0. A new start then completes normally.
- N=8, signed: mcand=7, mplier=0xFD (-3) -> done after 17 edges, product=0xFFEB (-21). Change mcand/mplier while busy -> result unaffected.
- N=8, signed: mcand=0x80, mplier=0x80 -> product=0x4000. mcand=0xFF, mplier=0xFF -> product=0x0001.
- N=8, unsigned: mcand=0xFF, mplier=0xFF -> product=0xFE01. mcand=0x80, mplier=0x02 -> product=0x0100.
- Handshake: hold start high for 40 cycles -> exactly one multiply, done held high until start falls, then IDLE. Pulse start during busy -> ignored, latency unchanged.
- Parameter sweep N=2, 4, 16: exhaustive (N=2,4) or 1000 random (N=16) operand pairs in both modes, checked against a reference product. Latency is 2N+1 edges in every case.
